seg7_capture: RTL

- Receiver for the team's multiplexed 7-segment display bus.
- Samples the active-low segment lines and the active-low one-hot digit strobes that drive the board display.
- Filters ghosting during digit switching and decodes each glyph back to its 4-bit hex value.
- Publishes a coherent multi-digit word once per refresh frame; used for display loop-back self-check and for reading display-driven peripherals.

---
 rtl/seg7_pkg.sv | 47 ++++
 rtl/seg7_decode.sv | 26 ++
 rtl/seg7_capture.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display bus.
// Holds the glyph table used by both the encoder and the capture decoder,
// the dark-digit pattern, the segment bit order and the decode result type.
package seg7_pkg;

  // Segment bit positions on the bus (active low).
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_W = 7;

  // All segments off: a dark digit.
  localparam logic [SEG_W-1:0] BLANK = 7'b1111111;

  // Glyph table, entry n is the active-low pattern for hex digit n.
  // Written g..a (bit6..bit0). Entry 15 comes first in the concatenation.
  localparam logic [15:0][SEG_W-1:0] GLYPH_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0011000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Result of decoding one glyph.
  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] nibble;
  } glyph_info_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational glyph decoder: 7-bit active-low pattern -> {legal, blank, nibble}.
// Ports: seg (in, 7 segment lines), info (out, decode result).
// Unknown patterns come back illegal with nibble 0; the dark pattern is legal and blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output glyph_info_t      info
);

  always_comb begin
    info = '{legal: 1'b0, blank: 1'b0, nibble: 4'h0};
    if (seg == BLANK) begin
      info.legal = 1'b1;
      info.blank = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (seg == GLYPH_TABLE[i]) begin
          info.legal  = 1'b1;
          info.nibble = 4'(i);
        end
      end
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// Capture of a multiplexed 7-segment display bus back into a hex word.
// Ports: clk, rst_n (sync, active low), seg/dig_sel (active-low bus), err_clr;
// value/digit_valid/blank (last frame), frame_valid & stale pulses, sticky err.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEG_W-1:0]      seg,
  input  logic [DIGITS-1:0]     dig_sel,
  input  logic                  err_clr,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [DIGITS-1:0]     blank,
  output logic                  frame_valid,
  output logic                  stale,
  output logic                  err
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 2);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  // Two-flop synchronisers, idle bus is all ones.
  logic [SEG_W-1:0]    seg_m, seg_s;
  logic [DIGITS-1:0]   dig_m, dig_s;
  // Previous synchronised pair for the stability compare.
  logic [SEG_W-1:0]    seg_prev;
  logic [DIGITS-1:0]   dig_prev;
  logic [CW-1:0]       cnt;

  // Per-frame shadow slots and which slots have been filled.
  logic [4*DIGITS-1:0] shadow_val;
  logic [DIGITS-1:0]   shadow_legal;
  logic [DIGITS-1:0]   shadow_blank;
  logic [DIGITS-1:0]   seen;
  logic                pub_pend;

  // Watchdog: only armed once something has been captured.
  logic [WW-1:0]       wd_cnt;
  logic                wd_armed;

  glyph_info_t         info;
  logic [DIGITS-1:0]   dig_act;
  logic                one_hot;
  logic                same;
  logic                capture;
  logic [DIGITS-1:0]   seen_nxt;

  seg7_decode u_decode (
    .seg  (seg_s),
    .info (info)
  );

  always_comb begin
    dig_act  = ~dig_s;
    one_hot  = (dig_act != '0) && ((dig_act & (dig_act - DIGITS'(1))) == '0);
    same     = ({dig_s, seg_s} == {dig_prev, seg_prev});
    // Fires on the one cycle where cnt steps to its saturation value;
    // once saturated the strobe cannot repeat until the pair changes.
    capture  = same && (cnt == CNT_PRE) && one_hot;
    seen_nxt = seen | dig_act;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_m        <= BLANK;
      seg_s        <= BLANK;
      dig_m        <= '1;
      dig_s        <= '1;
      seg_prev     <= BLANK;
      dig_prev     <= '1;
      cnt          <= '0;
      shadow_val   <= '0;
      shadow_legal <= '0;
      shadow_blank <= '0;
      seen         <= '0;
      pub_pend     <= 1'b0;
      wd_cnt       <= '0;
      wd_armed     <= 1'b0;
      value        <= '0;
      digit_valid  <= '0;
      blank        <= '0;
      frame_valid  <= 1'b0;
      stale        <= 1'b0;
      err          <= 1'b0;
    end else begin
      seg_m    <= seg;
      seg_s    <= seg_m;
      dig_m    <= dig_sel;
      dig_s    <= dig_m;
      seg_prev <= seg_s;
      dig_prev <= dig_s;

      if (!same) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end

      frame_valid <= 1'b0;
      stale       <= 1'b0;

      if (capture) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (dig_act[i]) begin
            shadow_val[4*i +: 4] <= info.nibble;
            shadow_legal[i]      <= info.legal;
            shadow_blank[i]      <= info.blank;
          end
        end
      end

      // Setting an error beats a simultaneous clear.
      if (capture && !info.legal) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end

      // Publish one cycle after the last slot lands so the copy sees it.
      if (pub_pend) begin
        value       <= shadow_val;
        digit_valid <= shadow_legal;
        blank       <= shadow_blank;
        frame_valid <= 1'b1;
        pub_pend    <= 1'b0;
        seen        <= '0;
      end else if (capture) begin
        seen     <= seen_nxt;
        pub_pend <= (seen_nxt == '1);
      end

      if (capture) begin
        wd_cnt   <= '0;
        wd_armed <= 1'b1;
      end else if (wd_armed) begin
        wd_cnt <= wd_cnt + WW'(1);
        if (wd_cnt == WD_LAST) begin
          // Expired: one stale pulse, then hold until the next capture.
          stale       <= 1'b1;
          wd_armed    <= 1'b0;
          digit_valid <= '0;
          seen        <= '0;
          pub_pend    <= 1'b0;
        end
      end
    end
  end

endmodule
